instr_fetch_queue: RTL and testbench

Instruction fetch stage sitting directly downstream of the Olivia program counter/PC+4 adder.
- Owns the fetch PC and issues in-order 32-bit instruction requests to instruction memory over a valid/ready handshake.
- Buffers the returned words, each with its PC, in a DEPTH-entry FIFO and presents them to decode over a valid/ready handshake.
- Handles branch redirects by flushing the FIFO and discarding responses still in flight.

---
 rtl/instr_fetch_queue_if.sv | 57 +++++
 rtl/instr_fetch_queue.sv | 164 ++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory request/response,
// decode-side handshake and the visible fetch PC.
interface instr_fetch_queue_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned INSN_W = 32
);

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;

  logic              imem_resp_valid;
  logic [INSN_W-1:0] imem_resp_insn;

  logic              id_valid;
  logic [INSN_W-1:0] id_insn;
  logic [ADDR_W-1:0] id_pc;
  logic              id_ready;

  logic [ADDR_W-1:0] fetch_pc;

  // Fetch stage side.
  modport master (
    input  redirect_valid,
    input  redirect_pc,
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_insn,
    output id_valid,
    output id_insn,
    output id_pc,
    input  id_ready,
    output fetch_pc
  );

  // Environment side (memory, decode, redirect source).
  modport slave (
    output redirect_valid,
    output redirect_pc,
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_insn,
    input  id_valid,
    input  id_insn,
    input  id_pc,
    output id_ready,
    input  fetch_pc
  );

endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues in-order requests to
// instruction memory under a credit limit, buffers returned words with their
// PC in a FIFO for decode, and drops in-flight responses after a redirect.
module instr_fetch_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned INSN_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_fetch_queue_if.master  bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam ptr_t PtrOne = ptr_t'(1);
  localparam cnt_t CntOne = cnt_t'(1);

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  cnt_t              occ_q, occ_d;
  cnt_t              out_q, out_d;
  cnt_t              discard_q, discard_d;
  ptr_t              rd_ptr_q, rd_ptr_d;
  ptr_t              wr_ptr_q, wr_ptr_d;
  ptr_t              tag_rd_q, tag_rd_d;
  ptr_t              tag_wr_q, tag_wr_d;

  logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];
  logic [INSN_W-1:0] fifo_insn_q [DEPTH];
  logic [ADDR_W-1:0] tag_q       [DEPTH];

  logic              req_valid;
  logic              req_fire;
  logic              resp_keep;
  logic              id_valid;
  logic              id_pop;
  logic [CW:0]       inflight;

  // Low PC bits of a redirect target are forced to zero.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  // Request credit, handshake qualifiers and decode-side outputs.
  always_comb begin
    inflight  = {1'b0, occ_q} + {1'b0, out_q};
    req_valid = (state_q == StRun) && !bus.redirect_valid && (inflight < (CW + 1)'(DEPTH));
    req_fire  = req_valid && bus.imem_req_ready;
    // A redirect drops any same-cycle response and ignores id_ready.
    resp_keep = bus.imem_resp_valid && (discard_q == '0) && !bus.redirect_valid;
    id_valid  = (occ_q != '0);
    id_pop    = id_valid && bus.id_ready && !bus.redirect_valid;

    bus.imem_req_valid = req_valid;
    bus.imem_req_addr  = fetch_pc_q;
    bus.fetch_pc       = fetch_pc_q;
    bus.id_valid       = id_valid;
    bus.id_insn        = id_valid ? fifo_insn_q[rd_ptr_q] : '0;
    bus.id_pc          = id_valid ? fifo_pc_q[rd_ptr_q] : '0;
  end

  // Next-state for PC, pointers, counters and the RUN/DRAIN state.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    occ_d      = occ_q;
    out_d      = out_q;
    discard_d  = discard_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;

    if (bus.redirect_valid) begin
      fetch_pc_d = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      occ_d      = '0;
      out_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      tag_rd_d   = '0;
      tag_wr_d   = '0;
      // Everything still in flight becomes discard debt, less any word arriving now.
      discard_d  = out_q + discard_q - (bus.imem_resp_valid ? CntOne : '0);
      state_d    = (discard_d != '0) ? StDrain : StRun;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        tag_wr_d   = tag_wr_q + PtrOne;
      end

      if (bus.imem_resp_valid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CntOne;
        end else begin
          wr_ptr_d = wr_ptr_q + PtrOne;
          tag_rd_d = tag_rd_q + PtrOne;
        end
      end

      if (id_pop) begin
        rd_ptr_d = rd_ptr_q + PtrOne;
      end

      unique case ({resp_keep, id_pop})
        2'b10:   occ_d = occ_q + CntOne;
        2'b01:   occ_d = occ_q - CntOne;
        default: occ_d = occ_q;
      endcase

      unique case ({req_fire, resp_keep})
        2'b10:   out_d = out_q + CntOne;
        2'b01:   out_d = out_q - CntOne;
        default: out_d = out_q;
      endcase

      if ((state_q == StDrain) && (discard_d == '0)) begin
        state_d = StRun;
      end
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StRun;
      fetch_pc_q <= '0;
      occ_q      <= '0;
      out_q      <= '0;
      discard_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      occ_q      <= occ_d;
      out_q      <= out_d;
      discard_q  <= discard_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end

  // Storage arrays; contents are only meaningful behind valid pointers, so no reset.
  always_ff @(posedge clk) begin
    if (rst && req_fire) begin
      tag_q[tag_wr_q] <= fetch_pc_q;
    end
    if (rst && resp_keep) begin
      fifo_pc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
      fifo_insn_q[wr_ptr_q] <= bus.imem_resp_insn;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed phases followed by random traffic, each
// cycle compared against a queue-based model of the fetch stage.
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned INSN_W = 32;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [INSN_W-1:0] insn;
  } ent_t;

  typedef struct {
    logic [INSN_W-1:0] insn;
    int                due;
  } mresp_t;

  logic clk;
  logic rst;

  instr_fetch_queue_if #(.ADDR_W(ADDR_W), .INSN_W(INSN_W)) bus ();

  instr_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSN_W(INSN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  ent_t              m_fifo[$];
  logic [ADDR_W-1:0] m_tags[$];
  int                m_discard;
  logic [ADDR_W-1:0] m_pc;

  // Memory environment: in-order responses with a per-request delay.
  mresp_t            mem_q[$];

  int n_checks;
  int n_fail;
  int cyc;
  bit chk_en;

  task automatic chk(input string tag, input logic [ADDR_W-1:0] obs,
                     input logic [ADDR_W-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic cycle(input logic rst_v, input logic rv, input logic [ADDR_W-1:0] rpc,
                       input logic rdy, input logic idr, input int dly);
    logic              resp_v;
    logic [INSN_W-1:0] resp_i;
    logic              exp_req;
    logic              dut_fire;
    logic [ADDR_W-1:0] dut_addr;
    ent_t              e;
    mresp_t            m;
    int                last;

    resp_v = rst_v && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    resp_i = resp_v ? mem_q[0].insn : '0;

    rst                 = rst_v;
    bus.redirect_valid  = rv;
    bus.redirect_pc     = rpc;
    bus.imem_req_ready  = rdy;
    bus.imem_resp_valid = resp_v;
    bus.imem_resp_insn  = resp_i;
    bus.id_ready        = idr;
    #1;

    exp_req = (m_discard == 0) && !rv && ((m_fifo.size() + m_tags.size()) < DEPTH);
    if (chk_en) begin
      chk("req_valid", {63'd0, bus.imem_req_valid}, {63'd0, exp_req});
      chk("req_addr", bus.imem_req_addr, m_pc);
      chk("fetch_pc", bus.fetch_pc, m_pc);
      chk("id_valid", {63'd0, bus.id_valid}, {63'd0, m_fifo.size() > 0});
      chk("id_pc", bus.id_pc, (m_fifo.size() > 0) ? m_fifo[0].pc : '0);
      chk("id_insn", {32'd0, bus.id_insn}, {32'd0, (m_fifo.size() > 0) ? m_fifo[0].insn : 32'd0});
    end
    dut_fire = bus.imem_req_valid && rdy;
    dut_addr = bus.imem_req_addr;

    @(posedge clk);

    if (!rst_v) begin
      m_fifo.delete();
      m_tags.delete();
      m_discard = 0;
      m_pc      = '0;
    end else if (rv) begin
      m_discard = m_discard + m_tags.size() - (resp_v ? 1 : 0);
      m_tags.delete();
      m_fifo.delete();
      m_pc = {rpc[ADDR_W-1:2], 2'b00};
    end else begin
      if ((m_fifo.size() > 0) && idr) void'(m_fifo.pop_front());
      if (resp_v) begin
        if (m_discard > 0) begin
          m_discard--;
        end else if (m_tags.size() > 0) begin
          e.pc   = m_tags.pop_front();
          e.insn = resp_i;
          m_fifo.push_back(e);
        end
      end
      if (exp_req && rdy) begin
        m_tags.push_back(m_pc);
        m_pc = m_pc + 64'd4;
      end
    end

    if (!rst_v) begin
      mem_q.delete();
    end else begin
      if (resp_v) void'(mem_q.pop_front());
      if (dut_fire) begin
        last   = (mem_q.size() > 0) ? mem_q[mem_q.size()-1].due : -1;
        m.insn = INSN_W'(dut_addr >> 2);
        m.due  = (cyc + dly > last + 1) ? cyc + dly : last + 1;
        mem_q.push_back(m);
      end
    end

    cyc++;
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic rdy, input logic idr, input int dly);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, rdy, idr, dly);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    chk_en    = 1'b0;
    m_discard = 0;
    m_pc      = '0;

    // Reset, then steady fetch with 1-cycle memory and decode always ready.
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1);
    run(20, 1'b1, 1'b1, 1);

    // Decode stalled: FIFO fills to DEPTH and requests stop, then drain.
    run(12, 1'b1, 1'b0, 1);
    run(10, 1'b1, 1'b1, 1);

    // Long memory latency, redirect with requests outstanding.
    run(8, 1'b0, 1'b1, 1);
    run(3, 1'b1, 1'b1, 5);
    cycle(1'b1, 1'b1, 64'h103, 1'b1, 1'b1, 5);
    run(20, 1'b1, 1'b1, 5);

    // Redirect coincident with a response while two entries are queued.
    run(10, 1'b0, 1'b1, 1);
    run(3, 1'b1, 1'b0, 1);
    cycle(1'b1, 1'b1, 64'h2000, 1'b0, 1'b1, 1);
    run(4, 1'b0, 1'b1, 1);
    run(6, 1'b1, 1'b1, 1);

    // Address wrap at the top of the address space.
    run(6, 1'b0, 1'b1, 1);
    cycle(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF4, 1'b1, 1'b1, 1);
    run(10, 1'b1, 1'b1, 1);

    // Reset with a full FIFO, fetch restarts at zero.
    run(10, 1'b1, 1'b0, 1);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 1);
    run(10, 1'b1, 1'b1, 1);

    // Random traffic with occasional redirects.
    for (int i = 0; i < 2000; i++) begin
      cycle(1'b1,
            $urandom_range(0, 99) < 4,
            {$urandom(), $urandom()},
            $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 60,
            int'($urandom_range(1, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
